// File: rtl/serial_input_port_if.sv
// Serial input port signal bundle: serial line, bus-read enable and the status flags.
// The W bus itself stays a plain inout on the port so the three-state driver resolves at the bus.
interface serial_input_port_if;
   logic SERIAL_IN;
   logic Ei;
   logic READY;
   logic FRAME_ERR;
   logic OVERRUN;

   modport slave (
      input  SERIAL_IN,
      input  Ei,
      output READY,
      output FRAME_ERR,
      output OVERRUN
   );

   modport master (
      output SERIAL_IN,
      output Ei,
      input  READY,
      input  FRAME_ERR,
      input  OVERRUN
   );
endinterface

// File: rtl/serial_input_port.sv
// SAP-II serial input port: receives start/8N/stop frames into a holding register read onto WBUS.
// Define SERIAL_IN_SYNC_EN to pass SERIAL_IN through a 2-flop synchronizer (2 cycles extra latency).
module serial_input_port #(
   parameter int BIT_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              CLR,
   inout  wire  [7:0]        WBUS,
   serial_input_port_if.slave port
);
   localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_reg, state_next;
   logic [7:0]    hold_reg, hold_next;
   logic [7:0]    shift_reg, shift_next;
   logic [2:0]    bit_cnt_reg, bit_cnt_next;
   logic [CW-1:0] cyc_cnt_reg, cyc_cnt_next;
   logic          ready_reg, ready_next;
   logic          ferr_reg, ferr_next;
   logic          ovr_reg, ovr_next;
   logic          prev_rx_reg;
   logic          seen_high_reg, seen_high_next;
   logic          rx;
   logic          rx_valid;

`ifdef SERIAL_IN_SYNC_EN
   logic [1:0] sync_reg;
   logic [1:0] valid_reg;

   // valid_reg marks when the synchronizer holds real line samples rather than its reset ones
   always_ff @(posedge CLK) begin
      if (CLR) begin
         sync_reg  <= 2'b11;
         valid_reg <= 2'b00;
      end else begin
         sync_reg  <= {sync_reg[0], port.SERIAL_IN};
         valid_reg <= {valid_reg[0], 1'b1};
      end
   end

   assign rx       = sync_reg[1];
   assign rx_valid = valid_reg[1];
`else
   assign rx       = port.SERIAL_IN;
   assign rx_valid = 1'b1;
`endif

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_reg     <= IDLE;
         hold_reg      <= 8'h00;
         shift_reg     <= 8'h00;
         bit_cnt_reg   <= 3'd0;
         cyc_cnt_reg   <= '0;
         ready_reg     <= 1'b0;
         ferr_reg      <= 1'b0;
         ovr_reg       <= 1'b0;
         prev_rx_reg   <= 1'b1;
         seen_high_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hold_reg      <= hold_next;
         shift_reg     <= shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         cyc_cnt_reg   <= cyc_cnt_next;
         ready_reg     <= ready_next;
         ferr_reg      <= ferr_next;
         ovr_reg       <= ovr_next;
         prev_rx_reg   <= rx;
         seen_high_reg <= seen_high_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      hold_next      = hold_reg;
      shift_next     = shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      cyc_cnt_next   = cyc_cnt_reg;
      // a read on this edge is applied before any frame completion below
      ready_next     = ready_reg & ~port.Ei;
      ferr_next      = ferr_reg & ~port.Ei;
      ovr_next       = ovr_reg & ~port.Ei;
      // the forced-high prev_rx after reset must not turn a line stuck low into a start edge
      seen_high_next = seen_high_reg | (rx_valid & rx);

      case (state_reg)
         IDLE: begin
            if (seen_high_reg && prev_rx_reg && !rx) begin
               state_next   = START;
               cyc_cnt_next = HALF_LOAD;
            end
         end
         START: begin
            if (cyc_cnt_reg != '0) begin
               cyc_cnt_next = cyc_cnt_reg - CNT_ONE;
            end else if (!rx) begin
               state_next   = DATA;
               bit_cnt_next = 3'd0;
               cyc_cnt_next = FULL_LOAD;
            end else begin
               state_next   = IDLE;
            end
         end
         DATA: begin
            if (cyc_cnt_reg != '0) begin
               cyc_cnt_next = cyc_cnt_reg - CNT_ONE;
            end else begin
               shift_next   = {rx, shift_reg[7:1]};
               cyc_cnt_next = FULL_LOAD;
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            if (cyc_cnt_reg != '0) begin
               cyc_cnt_next = cyc_cnt_reg - CNT_ONE;
            end else begin
               state_next = IDLE;
               if (rx) begin
                  if (!ready_next) begin
                     hold_next  = shift_reg;
                     ready_next = 1'b1;
                  end else begin
                     ovr_next   = 1'b1;
                  end
               end else begin
                  ferr_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign WBUS           = port.Ei ? hold_reg : 8'bzzzz_zzzz;
   assign port.READY     = ready_reg;
   assign port.FRAME_ERR = ferr_reg;
   assign port.OVERRUN   = ovr_reg;
endmodule

// File: doc/serial_input_port.md
Name: serial_input_port

Overview:
Serial input port for the SAP-II computer. It receives asynchronous framed bytes from an external device and assembles them into a holding register. The controller reads that register onto the W bus through a three-state driver. The block is the bus writer for the data that the accumulator later loads; it raises READY so the program can poll for a new byte.

Parameters:
BIT_CYCLES, 4, CLK cycles per serial bit; must be even and at least 2.

Ports:
CLK  input  1  system clock; all state updates on posedge.
CLR  input  1  reset; synchronous, active-high.
SERIAL_IN  input  1  serial line.
- Idle high.
- Frame: start bit 0, then 8 data bits LSB first, then stop bit 1.
WBUS  inout  8  W bus; driven with the holding register when Ei=1, otherwise 8'bzzzz_zzzz.
Ei  input  1  enable port onto the W bus (read).
READY  output  1  unread byte present in the holding register.
FRAME_ERR  output  1  sticky; last frame had stop bit = 0.
OVERRUN  output  1  sticky; a completed byte was dropped because READY was already 1.

Behaviour:
- Reset (CLR=1 at posedge), regardless of state mid-frame:
  - state=IDLE, holding register=8'h00, shift register=0, bit counter=0, cycle counter=0.
  - READY=0, FRAME_ERR=0, OVERRUN=0.
  - The previous-line register is set to 1.
  - WBUS follows Ei combinationally, as in normal operation.
- The line value used internally is "rx": SERIAL_IN sampled at posedge, or synchronized per the optional feature. prev_rx holds rx from the prior edge.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - On an edge with prev_rx=1 and rx=0, call this edge E0: go to START and load cycle counter = BIT_CYCLES/2-1.
  - A line held low since reset does not trigger a start.
- START:
  - Count down. At counter 0, i.e. edge E0+BIT_CYCLES/2, sample rx.
  - rx=0: go to DATA, bit counter=0, cycle counter=BIT_CYCLES-1.
  - rx=1: glitch; return to IDLE. No flags change.
- DATA:
  - Each time the cycle counter reaches 0, shift rx into bit 7 of the shift register (right shift, so the first bit received ends in bit 0) and reload the counter.
  - After the 8th sample go to STOP.
  - Data bit n is sampled at edge E0+BIT_CYCLES/2+(n+1)*BIT_CYCLES.
- STOP:
  - Sample at edge E0+BIT_CYCLES/2+9*BIT_CYCLES (edge E0+38 for default), then go to IDLE.
  - rx=1, READY=0 (after applying a same-edge read): holding register <= shift register and READY<=1, visible after that edge.
  - rx=1, READY=1 and not cleared: byte dropped, holding register unchanged, OVERRUN<=1.
  - rx=0: byte discarded, FRAME_ERR<=1, READY unchanged.
- Read:
  - WBUS = holding register whenever Ei=1, whether or not READY=1.
  - Any posedge with Ei=1 clears READY, FRAME_ERR and OVERRUN.
- Simultaneous read and completion on the same edge:
  - The read is applied first.
  - The new byte loads and READY stays 1; no overrun.
- A new frame may start in the IDLE cycle right after STOP; there is no extra inter-frame gap.
- Ei has no effect on the receive state machine.

Optional Feature:
Macro SERIAL_IN_SYNC_EN.
- Defined: SERIAL_IN passes through a 2-flop synchronizer before the rx register. Every timing reference above shifts 2 cycles later relative to SERIAL_IN.
- Undefined: SERIAL_IN is registered once (rx). No synchronizer; 0 extra latency.
- Reset sets all synchronizer flops to 1.

Test Plan:
1. Reset then single frame:
   - Stimulus: CLR pulse; send 0x5A (BIT_CYCLES=4, line changes every 4 cycles).
   - Response: READY rises 38 cycles after E0. Ei=1 drives WBUS=8'h5A; the next edge clears READY. With Ei=0, WBUS=zzzz_zzzz.
2. Glitch rejection:
   - Stimulus: SERIAL_IN low for 1 cycle, then high.
   - Response: state returns to IDLE, READY=0, no flags; a following frame 0xC3 is received correctly.
3. Framing error:
   - Stimulus: send 0xFF with stop bit=0.
   - Response: FRAME_ERR=1, READY=0, holding register keeps its prior value. Ei pulse clears FRAME_ERR.
4. Overrun:
   - Stimulus: send 0x11 then 0x22 without reading.
   - Response: READY=1, OVERRUN=1, WBUS (Ei=1) = 8'h11.
5. Simultaneous read and completion:
   - Stimulus: READY=1 with 0x11; Ei asserted exactly on the stop-sample edge of 0x22.
   - Response: READY=1, OVERRUN=0, next read gives 8'h22.
6. Reset mid-frame:
   - Stimulus: CLR at data bit 4 of 0xA5; then send 0x3C.
   - Response: all outputs at reset values; 0x3C received intact. With SERIAL_IN_SYNC_EN defined, READY arrives at E0+40.
